// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper coil driver and decoder blocks.
// Coil patterns, phase type and FSM encoding live here so every block
// that produces or interprets coil lines agrees on the same meaning.
package stepper_pkg;

  // Coil line patterns, bit order {A,B,C,D}
  localparam logic [3:0] COIL_A   = 4'b1000;
  localparam logic [3:0] COIL_B   = 4'b0100;
  localparam logic [3:0] COIL_C   = 4'b0010;
  localparam logic [3:0] COIL_D   = 4'b0001;
  localparam logic [3:0] COIL_OFF = 4'b0000;

  // Wave-drive phase index: A=0, B=1, C=2, D=3; forward is +1 mod 4
  typedef logic [1:0] phase_t;

  // Phase deltas (new - old, mod 4) as seen by the tracker
  localparam phase_t DELTA_HOLD = 2'd0;
  localparam phase_t DELTA_FWD  = 2'd1;
  localparam phase_t DELTA_SKIP = 2'd2;
  localparam phase_t DELTA_REV  = 2'd3;

  // Tracker state: IDLE until a one-hot pattern seeds the phase
  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } fsm_state_t;

  // Classification of a coil pattern
  typedef enum logic [1:0] {
    PAT_OFF     = 2'd0,
    PAT_ONEHOT  = 2'd1,
    PAT_ILLEGAL = 2'd2
  } pattern_class_t;

  // De-energized, single-coil, or anything else (multi-hot)
  function automatic pattern_class_t classify_pattern(input logic [3:0] coils);
    pattern_class_t cls;
    case (coils)
      COIL_OFF:                        cls = PAT_OFF;
      COIL_A, COIL_B, COIL_C, COIL_D:  cls = PAT_ONEHOT;
      default:                         cls = PAT_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Phase index of a one-hot pattern; other patterns map to 0 and are
  // never used as a phase by the caller
  function automatic phase_t coil_to_phase(input logic [3:0] coils);
    phase_t ph;
    case (coils)
      COIL_A:  ph = 2'd0;
      COIL_B:  ph = 2'd1;
      COIL_C:  ph = 2'd2;
      COIL_D:  ph = 2'd3;
      default: ph = 2'd0;
    endcase
    return ph;
  endfunction

  // Modulo-4 distance from the old phase to the new one
  function automatic phase_t phase_delta(input phase_t new_ph, input phase_t old_ph);
    return phase_t'(new_ph - old_ph);
  endfunction

endpackage

// File: rtl/input_sync_filter.sv
// Coil input conditioning: a multi-stage synchronizer for the asynchronous
// coil lines followed by a stability filter. A pattern is reported once,
// with a one-cycle accept strobe, on the cycle the synchronized value has
// been seen STABLE_CYCLES times in a row. Any change restarts the run.
module input_sync_filter
  import stepper_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] coils_in,
  output logic [3:0] pattern_out,
  output logic       accept_out
);

  localparam int SW = SYNC_STAGES * 4;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  // Synchronizer chain, packed: lowest nibble is the first stage
  logic [SW-1:0] sync_q;
  logic [SW-1:0] sync_d;
  logic [3:0]    sync_out;

  // Filter state
  logic [3:0]    last_q,   last_d;
  logic [CW-1:0] count_q,  count_d;
  logic          accept_q, accept_d;

  // Shift the raw lines one stage deeper per clock
  always_comb begin
    sync_d = {sync_q[SW-5:0], coils_in};
  end

  assign sync_out = sync_q[SW-1 -: 4];

  // Count consecutive equal samples; strobe exactly once at the threshold
  always_comb begin
    last_d   = last_q;
    count_d  = count_q;
    accept_d = 1'b0;
    if (sync_out != last_q) begin
      // New pattern: this sample is the first of a fresh run
      last_d   = sync_out;
      count_d  = COUNT_ONE;
      accept_d = (STABLE_CYCLES == 1);
    end else if (count_q < STABLE_MAX) begin
      count_d  = count_q + COUNT_ONE;
      accept_d = (count_d == STABLE_MAX);
    end
  end

  // Register synchronizer and filter; everything clears to 4'b0000
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      last_q   <= COIL_OFF;
      count_q  <= '0;
      accept_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      last_q   <= last_d;
      count_q  <= count_d;
      accept_q <= accept_d;
    end
  end

  assign pattern_out = last_q;
  assign accept_out  = accept_q;

endmodule

// File: rtl/stepper_phase_decoder.sv
// Wave-drive stepper phase decoder. Watches the four coil lines of a
// unipolar stepper, recovers step events and direction, keeps a wrapping
// signed position count, and flags illegal patterns and skipped phases.
// Decode, tracking FSM, position and idle timeout all live here; input
// conditioning is delegated to input_sync_filter.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int POS_WIDTH     = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           coils_in,
  input  logic                 clear,
  output logic                 step_pulse,
  output logic                 dir_out,
  output logic [POS_WIDTH-1:0] position,
  output logic                 moving,
  output logic                 illegal_err,
  output logic                 skip_err,
  output logic [1:0]           phase_out
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0]        IDLE_MAX = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0]        IDLE_ONE = IW'(1);
  localparam logic [POS_WIDTH-1:0] POS_ONE  = POS_WIDTH'(1);

  // Conditioned input
  logic [3:0]     acc_pattern;
  logic           acc_strobe;

  // Decode of the accepted pattern
  pattern_class_t pat_class;
  phase_t         new_phase;
  phase_t         delta;

  // Tracker state and registered outputs
  fsm_state_t           state_q,       state_d;
  phase_t               phase_q,       phase_d;
  logic [POS_WIDTH-1:0] position_q,    position_d;
  logic                 dir_q,         dir_d;
  logic                 step_pulse_q,  step_pulse_d;
  logic                 illegal_err_q, illegal_err_d;
  logic                 skip_err_q,    skip_err_d;
  logic [IW-1:0]        idle_cnt_q,    idle_cnt_d;
  logic                 moving_q,      moving_d;

  // Events raised by this cycle's accepted pattern
  logic illegal_evt;
  logic skip_evt;

  input_sync_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk         (clk),
    .rst_n       (rst_n),
    .coils_in    (coils_in),
    .pattern_out (acc_pattern),
    .accept_out  (acc_strobe)
  );

  assign pat_class = classify_pattern(acc_pattern);
  assign new_phase = coil_to_phase(acc_pattern);
  assign delta     = phase_delta(new_phase, phase_q);

  // Phase tracking, step/direction decode and position update
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    position_d   = position_q;
    dir_d        = dir_q;
    step_pulse_d = 1'b0;
    illegal_evt  = 1'b0;
    skip_evt     = 1'b0;

    if (acc_strobe) begin
      unique case (pat_class)
        PAT_OFF: begin
          // De-energized coils: the rotor holds, nothing to track
        end
        PAT_ONEHOT: begin
          if (state_q == IDLE) begin
            // First valid phase only seeds the tracker
            phase_d = new_phase;
            state_d = TRACK;
          end else begin
            unique case (delta)
              DELTA_FWD: begin
                position_d   = position_q + POS_ONE;
                dir_d        = 1'b1;
                step_pulse_d = 1'b1;
                phase_d      = new_phase;
              end
              DELTA_REV: begin
                position_d   = position_q - POS_ONE;
                dir_d        = 1'b0;
                step_pulse_d = 1'b1;
                phase_d      = new_phase;
              end
              DELTA_SKIP: begin
                // Direction is ambiguous: resync phase, do not count
                skip_evt = 1'b1;
                phase_d  = new_phase;
              end
              default: begin
                // Same phase re-accepted: no motion
              end
            endcase
          end
        end
        default: begin
          // Multi-hot: tracking is lost until the next one-hot reseeds
          illegal_evt = 1'b1;
          state_d     = IDLE;
        end
      endcase
    end
  end

  // Sticky error flags with clear; a same-cycle event beats clear
  always_comb begin
    illegal_err_d = illegal_err_q;
    skip_err_d    = skip_err_q;
    if (clear) begin
      illegal_err_d = 1'b0;
      skip_err_d    = 1'b0;
    end
    if (illegal_evt) begin
      illegal_err_d = 1'b1;
    end
    if (skip_evt) begin
      skip_err_d = 1'b1;
    end
  end

  // Idle counter: restarts on each step, saturates at the timeout
  always_comb begin
    if (step_pulse_d) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q < IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IDLE_ONE;
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
    moving_d = (idle_cnt_d < IDLE_MAX);
  end

  // Tracker FSM and all registered outputs; clear zeroes position last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      position_q    <= '0;
      dir_q         <= 1'b1;
      step_pulse_q  <= 1'b0;
      illegal_err_q <= 1'b0;
      skip_err_q    <= 1'b0;
      idle_cnt_q    <= IDLE_MAX;
      moving_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      position_q    <= clear ? '0 : position_d;
      dir_q         <= dir_d;
      step_pulse_q  <= step_pulse_d;
      illegal_err_q <= illegal_err_d;
      skip_err_q    <= skip_err_d;
      idle_cnt_q    <= idle_cnt_d;
      moving_q      <= moving_d;
    end
  end

  assign step_pulse  = step_pulse_q;
  assign dir_out     = dir_q;
  assign position    = position_q;
  assign moving      = moving_q;
  assign illegal_err = illegal_err_q;
  assign skip_err    = skip_err_q;
  assign phase_out   = phase_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Scoreboard bench for stepper_phase_decoder: stimulus pushes expected
// step events (direction, position, arrival cycle); a monitor pops and
// compares on every step_pulse. State flags are checked directly.
module tb_stepper_phase_decoder;
  import stepper_pkg::*;

  localparam int PW   = 4;
  localparam int SYNC = 2;
  localparam int STAB = 4;
  localparam int TO   = 50;
  localparam int LAT  = SYNC + STAB + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    coils_in = 4'b0000;
  logic          clear = 1'b0;
  logic          step_pulse;
  logic          dir_out;
  logic [PW-1:0] position;
  logic          moving;
  logic          illegal_err;
  logic          skip_err;
  logic [1:0]    phase_out;

  stepper_phase_decoder #(
    .POS_WIDTH     (PW),
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STAB),
    .IDLE_TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coils_in    (coils_in),
    .clear       (clear),
    .step_pulse  (step_pulse),
    .dir_out     (dir_out),
    .position    (position),
    .moving      (moving),
    .illegal_err (illegal_err),
    .skip_err    (skip_err),
    .phase_out   (phase_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic          dir;
    logic [PW-1:0] pos;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s = 0x%0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every step pulse must match the oldest expected step
  always @(negedge clk) begin
    if (rst_n && step_pulse) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: got pulse dir=%0d pos=0x%0h at cycle %0d, expected none",
                 dir_out, position, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("step_dir",   32'(dir_out),  32'(mon_e.dir));
        chk("step_pos",   32'(position), 32'(mon_e.pos));
        chk("step_cycle", 32'(cyc),      32'(mon_e.cyc));
      end
    end
  end

  // Called at a negedge: change coils, record the step this must produce
  task automatic drive(input logic [3:0] pat, input bit exp_step,
                       input logic exp_dir, input logic [PW-1:0] exp_pos);
    exp_t e;
    coils_in = pat;
    if (exp_step) begin
      e.dir = exp_dir;
      e.pos = exp_pos;
      e.cyc = cyc + LAT;
      sb_q.push_back(e);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step(input logic [3:0] pat, input bit exp_step,
                      input logic exp_dir, input logic [PW-1:0] exp_pos);
    drive(pat, exp_step, exp_dir, exp_pos);
    hold(20);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_step"},    32'(step_pulse),  32'd0);
    chk({tag, "_dir"},     32'(dir_out),     32'd1);
    chk({tag, "_pos"},     32'(position),    32'd0);
    chk({tag, "_moving"},  32'(moving),      32'd0);
    chk({tag, "_illegal"}, 32'(illegal_err), 32'd0);
    chk({tag, "_skip"},    32'(skip_err),    32'd0);
    chk({tag, "_phase"},   32'(phase_out),   32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  mcnt;
    bit  found;

    hold(3);
    chk_reset_values("reset");
    rst_n = 1'b1;
    hold(2);

    // Forward rotation A->B->C->D->A: four steps, first one seeds
    step(COIL_A, 0, 1'b1, 4'd0);
    step(COIL_B, 1, 1'b1, 4'd1);
    step(COIL_C, 1, 1'b1, 4'd2);
    step(COIL_D, 1, 1'b1, 4'd3);
    step(COIL_A, 1, 1'b1, 4'd4);
    chk("fwd_pos",     32'(position),    32'd4);
    chk("fwd_dir",     32'(dir_out),     32'd1);
    chk("fwd_phase",   32'(phase_out),   32'd0);
    chk("fwd_moving",  32'(moving),      32'd1);
    chk("fwd_illegal", 32'(illegal_err), 32'd0);
    chk("fwd_skip",    32'(skip_err),    32'd0);

    // Reverse rotation from phase A while tracking: every pattern steps
    step(COIL_D, 1, 1'b0, 4'd3);
    step(COIL_C, 1, 1'b0, 4'd2);
    step(COIL_B, 1, 1'b0, 4'd1);
    step(COIL_A, 1, 1'b0, 4'd0);
    chk("rev_pos", 32'(position), 32'd0);
    chk("rev_dir", 32'(dir_out),  32'd0);

    // Glitch: B for only 3 cycles is filtered out
    drive(COIL_B, 0, 1'b0, 4'd0);
    hold(3);
    step(COIL_A, 0, 1'b0, 4'd0);
    chk("glitch_pos",   32'(position),  32'd0);
    chk("glitch_phase", 32'(phase_out), 32'd0);

    // Skip A->C, then illegal 1100, then B only reseeds
    step(COIL_C, 0, 1'b0, 4'd0);
    chk("skip_flag",    32'(skip_err),    32'd1);
    chk("skip_pos",     32'(position),    32'd0);
    chk("skip_phase",   32'(phase_out),   32'd2);
    chk("skip_illegal", 32'(illegal_err), 32'd0);
    step(4'b1100, 0, 1'b0, 4'd0);
    chk("ill_flag",  32'(illegal_err), 32'd1);
    chk("ill_phase", 32'(phase_out),   32'd2);
    step(COIL_B, 0, 1'b0, 4'd0);
    chk("seed_phase", 32'(phase_out), 32'd1);
    chk("seed_pos",   32'(position),  32'd0);
    step(COIL_C, 1, 1'b1, 4'd1);
    chk("sticky_illegal", 32'(illegal_err), 32'd1);
    chk("sticky_skip",    32'(skip_err),    32'd1);

    // Plain clear
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    hold(2);
    chk("clr_pos",     32'(position),    32'd0);
    chk("clr_illegal", 32'(illegal_err), 32'd0);
    chk("clr_skip",    32'(skip_err),    32'd0);
    chk("clr_phase",   32'(phase_out),   32'd2);

    // Clear on the step cycle: pulse and direction stay, position zeroes
    drive(COIL_D, 1, 1'b1, 4'd0);
    hold(LAT - 1);
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    hold(13);
    chk("clrstep_pos",   32'(position),  32'd0);
    chk("clrstep_phase", 32'(phase_out), 32'd3);

    // Clear on an illegal-pattern cycle: the flag still ends set
    drive(4'b0110, 0, 1'b0, 4'd0);
    hold(LAT - 1);
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    hold(13);
    chk("clrerr_illegal", 32'(illegal_err), 32'd1);
    chk("clrerr_phase",   32'(phase_out),   32'd3);
    step(COIL_D, 0, 1'b0, 4'd0);
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    hold(2);
    chk("clr2_illegal", 32'(illegal_err), 32'd0);

    // Wrap: 8 forward steps from 0 in a 4-bit counter
    step(COIL_A, 1, 1'b1, 4'd1);
    step(COIL_B, 1, 1'b1, 4'd2);
    step(COIL_C, 1, 1'b1, 4'd3);
    step(COIL_D, 1, 1'b1, 4'd4);
    step(COIL_A, 1, 1'b1, 4'd5);
    step(COIL_B, 1, 1'b1, 4'd6);
    step(COIL_C, 1, 1'b1, 4'd7);
    step(COIL_D, 1, 1'b1, 4'b1000);
    chk("wrap_pos", 32'(position), 32'b1000);

    // One reverse step back across the wrap, then measure moving
    drive(COIL_C, 1, 1'b0, 4'b0111);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (step_pulse) found = 1'b1;
    end
    chk("mv_pulse_seen", 32'(found), 32'd1);
    mcnt = 0;
    while (moving && mcnt < 200) begin
      mcnt++;
      @(negedge clk);
    end
    chk("mv_high_cycles", 32'(mcnt),     32'd50);
    chk("unwrap_pos",     32'(position), 32'b0111);
    chk("unwrap_dir",     32'(dir_out),  32'd0);

    // Reset in the middle of a step
    drive(COIL_D, 0, 1'b0, 4'd0);
    hold(4);
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    hold(3);
    rst_n = 1'b1;
    hold(20);
    chk("postrst_phase", 32'(phase_out), 32'd3);
    chk("postrst_pos",   32'(position),  32'd0);
    step(COIL_A, 1, 1'b1, 4'd1);
    chk("postrst_step_pos", 32'(position), 32'd1);

    hold(10);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
